pulse_meter_us: RTL

Measures the high time of an asynchronous input pulse in whole microseconds, the inverse of the microsecond delay timer: that block produces a delay from a count, this one produces a count from an observed delay. It sits beside the delay timers on the 125 MHz fabric clock and reports one result per arm request through a valid/ack handshake. Typical uses are echo-pulse ranging and measuring handshake widths from external peripherals.

---
 rtl/pulse_meter_pkg.sv | 14 +
 rtl/pulse_meter_us_sync.sv | 23 ++
 rtl/pulse_meter_us.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse meter: FSM state encoding and the fabric
// clock rate shared with the microsecond delay timers.
package pulse_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int unsigned CLK_PER_US_DFLT = 125;

endpackage

// File: rtl/pulse_meter_us_sync.sv
// Two-flop synchronizer for asynchronous inputs into the fabric clock domain.
module pulse_meter_us_sync #(
   parameter int unsigned BIT_LEN = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [BIT_LEN-1:0] d,
   output logic [BIT_LEN-1:0] q
);

   logic [BIT_LEN-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pulse_meter_us.sv
// Measures the high time of an asynchronous pulse in whole microseconds.
// Define PULSE_METER_TIMEOUT_EN to abort measurements after TIMEOUT_US.
module pulse_meter_us
   import pulse_meter_pkg::*;
#(
   parameter int unsigned BIT_LEN    = 16,
   parameter int unsigned CLK_PER_US = CLK_PER_US_DFLT,
   parameter int unsigned TIMEOUT_US = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               arm,
   input  logic               sig,
   output logic               busy,
   output logic               valid,
   output logic [BIT_LEN-1:0] width,
   output logic               overflow,
   output logic               timeout,
   input  logic               ack
);

   localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [PW-1:0] PRE_TOP = PW'(CLK_PER_US - 1);

   if (CLK_PER_US < 2 || TIMEOUT_US < 1 || TIMEOUT_US > (2 ** BIT_LEN) - 1) begin : g_bad_cfg
      $error("pulse_meter_us: invalid CLK_PER_US/TIMEOUT_US for BIT_LEN");
   end

   state_t             state, state_n;
   logic               sig_s, sig_d, rise, fall;
   logic [PW-1:0]      pre, pre_n, pre_step;
   logic [BIT_LEN-1:0] cnt, cnt_n, cnt_step, width_n;
   logic               ovf_step, ovf_n, valid_n, to_q, to_n;

   pulse_meter_us_sync #(.BIT_LEN(1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sig),
      .q     (sig_s)
   );

   assign rise    = sig_s & ~sig_d;
   assign fall    = ~sig_s & sig_d;
   assign busy    = (state == ST_ARMED) || (state == ST_MEASURE);
   assign timeout = to_q;

   always_comb begin
      state_n  = state;
      pre_n    = pre;
      cnt_n    = cnt;
      width_n  = width;
      valid_n  = valid;
      ovf_n    = overflow;
      to_n     = to_q;

      // One microsecond tick of the shared prescaler/counter, saturating.
      pre_step = pre + PW'(1);
      cnt_step = cnt;
      ovf_step = overflow;
      if (pre == PRE_TOP) begin
         pre_step = '0;
         if (cnt == '1) ovf_step = 1'b1;
         else           cnt_step = cnt + BIT_LEN'(1);
      end

      unique case (state)
         ST_IDLE: begin
            if (arm) begin
               state_n = ST_ARMED;
               pre_n   = '0;
               cnt_n   = '0;
               ovf_n   = 1'b0;
               to_n    = 1'b0;
            end
         end
         ST_ARMED: begin
            if (rise) begin
               state_n = ST_MEASURE;
               pre_n   = '0;
               cnt_n   = '0;
            end
`ifdef PULSE_METER_TIMEOUT_EN
            else begin
               pre_n = pre_step;
               cnt_n = cnt_step;
               if (cnt_step == BIT_LEN'(TIMEOUT_US)) begin
                  state_n = ST_DONE;
                  width_n = '0;
                  valid_n = 1'b1;
                  to_n    = 1'b1;
               end
            end
`endif
         end
         ST_MEASURE: begin
            pre_n = pre_step;
            cnt_n = cnt_step;
            ovf_n = ovf_step;
            if (fall) begin
               state_n = ST_DONE;
               width_n = cnt_step;
               valid_n = 1'b1;
            end
`ifdef PULSE_METER_TIMEOUT_EN
            else if (cnt_step == BIT_LEN'(TIMEOUT_US)) begin
               state_n = ST_DONE;
               width_n = BIT_LEN'(TIMEOUT_US);
               valid_n = 1'b1;
               to_n    = 1'b1;
            end
`endif
         end
         ST_DONE: begin
            if (ack) begin
               state_n = ST_IDLE;
               valid_n = 1'b0;
               ovf_n   = 1'b0;
               to_n    = 1'b0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         sig_d    <= 1'b0;
         pre      <= '0;
         cnt      <= '0;
         width    <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state    <= state_n;
         sig_d    <= sig_s;
         pre      <= pre_n;
         cnt      <= cnt_n;
         width    <= width_n;
         valid    <= valid_n;
         overflow <= ovf_n;
         to_q     <= to_n;
      end
   end

endmodule
